// File: rtl/apb_parity_regblock.sv
// APB4 slave holding ten identical 32-bit R/W registers, each split into three
// parity-protected fields; parity_error flags any field that disagrees with its stored parity.
module apb_parity_regblock #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  parity_error,
    input  logic                  s_apb_psel,
    input  logic                  s_apb_penable,
    input  logic                  s_apb_pwrite,
    input  logic [2:0]            s_apb_pprot,
    input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
    input  logic [31:0]           s_apb_pwdata,
    input  logic [3:0]            s_apb_pstrb,
    output logic                  s_apb_pready,
    output logic [31:0]           s_apb_prdata,
    output logic                  s_apb_pslverr
);

    localparam int NUM_REGS = 10;
    localparam int IDX_W    = 4;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic                  access;
    logic                  wr_en;
    logic [31:0]           rd_value;
    logic [31:0]           reg_value [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_perr;

    assign word_addr = {s_apb_paddr[ADDR_WIDTH-1:2], 2'b00};

    // Register index: r1 -> 0, r2[0..7] -> 1..8, r3 -> 9.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        hit = 1'b0;
        idx = '0;
        if (word_addr == ADDR_WIDTH'('h0000)) begin
            hit = 1'b1;
            idx = IDX_W'(0);
        end else if (word_addr >= ADDR_WIDTH'('h1000) && word_addr <= ADDR_WIDTH'('h101C)) begin
            hit = 1'b1;
            idx = IDX_W'(1) + IDX_W'(word_addr[4:2]);
        end else if (word_addr == ADDR_WIDTH'('h1FFC)) begin
            hit = 1'b1;
            idx = IDX_W'(9);
        end
    end

    // Gating with rst keeps the bus outputs quiet while reset is asserted.
    assign access = rst & s_apb_psel & s_apb_penable;
    assign wr_en  = access & s_apb_pwrite & hit;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [15:0] f1;
        logic [15:0] f1_next;
        logic [7:0]  f2;
        logic        f3;
        logic        p1;
        logic        p2;
        logic        p3;
        logic        sel;

        assign sel     = wr_en && (idx == IDX_W'(i));
        assign f1_next = {s_apb_pstrb[1] ? s_apb_pwdata[15:8] : f1[15:8],
                          s_apb_pstrb[0] ? s_apb_pwdata[7:0]  : f1[7:0]};

        always_ff @(posedge clk or negedge rst) begin
            // NOTE: data and parity reset together so the all-zero state is parity-consistent.
            if (!rst) begin
                f1 <= '0;
                f2 <= '0;
                f3 <= 1'b0;
                p1 <= 1'b0;
                p2 <= 1'b0;
                p3 <= 1'b0;
            end else if (sel) begin
                // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
                if (|s_apb_pstrb[1:0]) begin
                    f1 <= f1_next;
                    p1 <= ^f1_next;
                end
                if (s_apb_pstrb[2]) begin
                    f2 <= s_apb_pwdata[23:16];
                    p2 <= ^s_apb_pwdata[23:16];
                end
                if (s_apb_pstrb[3]) begin
                    f3 <= s_apb_pwdata[24];
                    p3 <= s_apb_pwdata[24];
                end
            end
        end

        assign reg_value[i] = {7'b0, f3, f2, f1};
        assign reg_perr[i]  = ((^f1) != p1) | ((^f2) != p2) | (f3 != p3);
    end

    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) rd_value = reg_value[i];
        end
    end

    assign s_apb_pready  = access;
    assign s_apb_prdata  = (access && hit && !s_apb_pwrite) ? rd_value : 32'h0;
    assign s_apb_pslverr = 1'b0;
    assign parity_error  = |reg_perr;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_apb_pprot, s_apb_paddr[1:0], s_apb_pwdata[31:25]};

endmodule

// File: tb/tb_apb_parity_regblock.sv
// Self-checking bench for apb_parity_regblock: directed scenarios plus random
// traffic compared against a byte-level register-map model.
module tb_apb_parity_regblock;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        parity_error;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [2:0]  pprot = 3'b0;
    logic [12:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [10];

    always #5 clk = ~clk;

    apb_parity_regblock #(.ADDR_WIDTH(13)) dut (
        .clk           (clk),
        .rst           (rst),
        .parity_error  (parity_error),
        .s_apb_psel    (psel),
        .s_apb_penable (penable),
        .s_apb_pwrite  (pwrite),
        .s_apb_pprot   (pprot),
        .s_apb_paddr   (paddr),
        .s_apb_pwdata  (pwdata),
        .s_apb_pstrb   (pstrb),
        .s_apb_pready  (pready),
        .s_apb_prdata  (prdata),
        .s_apb_pslverr (pslverr)
    );

    function automatic int addr_idx(input int a);
        int w;
        w = a & 32'h1FFC;
        if (w == 0) return 0;
        if (w >= 32'h1000 && w < 32'h1020) return 1 + (w - 32'h1000) / 4;
        if (w == 32'h1FFC) return 9;
        return -1;
    endfunction

    function automatic int reg_addr(input int i);
        if (i == 0) return 0;
        if (i == 9) return 32'h1FFC;
        return 32'h1000 + 4 * (i - 1);
    endfunction

    task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s);
        int i;
        i = addr_idx(a);
        if (i < 0) return;
        for (int k = 0; k < 4; k++)
            if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
        model[i] = model[i] & 32'h01FF_FFFF;
    endtask

    function automatic logic [31:0] model_read(input int a);
        int i;
        i = addr_idx(a);
        return (i < 0) ? 32'h0 : model[i];
    endfunction

    task automatic apb_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
        pprot = 3'($urandom);
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        model_write(int'(a), d, s);
    endtask

    task automatic apb_read(input logic [12:0] a, output logic [31:0] d,
                            output logic rdy, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        d = prdata; rdy = pready; err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        rdy, err;
        for (int i = 0; i < 10; i++) model[i] = 32'h0;
        #1;
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0 || pslverr !== 1'b0 || parity_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: pready=%b prdata=%h pslverr=%b perr=%b, required 0/0/0/0",
                     pready, prdata, pslverr, parity_error);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apb_read(13'(reg_addr(i)), d, rdy, err);
            checks++;
            if (d !== 32'h0 || rdy !== 1'b1 || err !== 1'b0 || parity_error !== 1'b0) begin
                errors++;
                $display("FAIL reset_read_%0d: data=%h rdy=%b err=%b perr=%b, required 00000000/1/0/0",
                         i, d, rdy, err, parity_error);
            end
        end
    endtask

    task automatic test_full_write();
        logic [31:0] d;
        logic        rdy, err;
        apb_write(13'h100C, 32'hFFFF_FFFF, 4'hF);
        apb_read(13'h100C, d, rdy, err);
        checks++;
        if (d !== 32'h01FF_FFFF) begin
            errors++;
            $display("FAIL full_write_r2_3: got %h, required 01ffffff", d);
        end
        for (int i = 0; i < 10; i++) begin
            apb_read(13'(reg_addr(i)), d, rdy, err);
            checks++;
            if (d !== model[i] || parity_error !== 1'b0) begin
                errors++;
                $display("FAIL full_write_others_%0d: got %h perr=%b, required %h perr=0",
                         i, d, parity_error, model[i]);
            end
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        logic        rdy, err;
        apb_write(13'h0000, 32'h0123_4567, 4'b0101);
        apb_read(13'h0000, d, rdy, err);
        checks++;
        if (d !== 32'h0023_0067 || parity_error !== 1'b0) begin
            errors++;
            $display("FAIL strobe_r1: got %h perr=%b, required 00230067 perr=0", d, parity_error);
        end
    endtask

    task automatic test_parity_force();
        logic [31:0] d;
        logic        rdy, err;
        apb_write(13'h1FFC, 32'h0000_ABCD, 4'hF);
        checks++;
        if (parity_error !== 1'b0) begin
            errors++;
            $display("FAIL parity_before_force: perr=%b, required 0", parity_error);
        end
        force dut.g_reg[9].f1 = 16'hABCC;
        #1;
        checks++;
        if (parity_error !== 1'b1) begin
            errors++;
            $display("FAIL parity_forced: perr=%b, required 1", parity_error);
        end
        release dut.g_reg[9].f1;
        apb_write(13'h1FFC, 32'h0000_ABCD, 4'hF);
        apb_read(13'h1FFC, d, rdy, err);
        checks++;
        if (d !== 32'h0000_ABCD || parity_error !== 1'b0) begin
            errors++;
            $display("FAIL parity_rewrite: got %h perr=%b, required 0000abcd perr=0", d, parity_error);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic        rdy, err;
        apb_read(13'h0800, d, rdy, err);
        checks++;
        if (d !== 32'h0 || rdy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_read: data=%h rdy=%b err=%b, required 0/1/0", d, rdy, err);
        end
        apb_write(13'h0800, 32'hFFFF_FFFF, 4'hF);
        apb_read(13'h0800, d, rdy, err);
        checks++;
        if (d !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_reread: data=%h err=%b, required 0/0", d, err);
        end
        for (int i = 0; i < 10; i++) begin
            apb_read(13'(reg_addr(i)), d, rdy, err);
            checks++;
            if (d !== model[i]) begin
                errors++;
                $display("FAIL unmapped_no_effect_%0d: got %h, required %h", i, d, model[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd, d;
        logic [12:0] a;
        for (int n = 0; n < 8; n++) begin
            a  = 13'(reg_addr($urandom_range(0, 9)) | $urandom_range(0, 3));
            wd = $urandom;
            @(posedge clk); #1;
            psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd; pstrb = 4'hF;
            @(posedge clk); #1;
            penable = 1'b1;
            @(posedge clk); #1;
            model_write(int'(a), wd, 4'hF);
            penable = 1'b0; pwrite = 1'b0;
            @(posedge clk); #1;
            penable = 1'b1;
            #1;
            d = prdata;
            @(posedge clk); #1;
            psel = 1'b0; penable = 1'b0;
            checks++;
            if (d !== model_read(int'(a))) begin
                errors++;
                $display("FAIL back_to_back_%0d: addr=%h got %h, required %h", n, a, d, model_read(int'(a)));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] wd, d;
        logic [12:0] a;
        logic        rdy, err;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) a = 13'($urandom);
            else a = 13'(reg_addr($urandom_range(0, 9)) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                apb_write(a, wd, 4'($urandom));
            end else begin
                apb_read(a, d, rdy, err);
                checks++;
                if (d !== model_read(int'(a)) || rdy !== 1'b1 || err !== 1'b0 || parity_error !== 1'b0) begin
                    errors++;
                    $display("FAIL random_read_%0d: addr=%h got %h rdy=%b err=%b perr=%b, required %h/1/0/0",
                             n, a, d, rdy, err, parity_error, model_read(int'(a)));
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic        rdy, err;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 13'h0000;
        pwdata = 32'h01FF_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0 || prdata !== 32'h0 || parity_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_write_outputs: pready=%b prdata=%h perr=%b, required 0/0/0",
                     pready, prdata, parity_error);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 10; i++) model[i] = 32'h0;
        for (int i = 0; i < 10; i++) begin
            apb_read(13'(reg_addr(i)), d, rdy, err);
            checks++;
            if (d !== model[i] || parity_error !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_write_%0d: got %h perr=%b, required %h perr=0",
                         i, d, parity_error, model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_strobe();
        test_parity_force();
        test_unmapped();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
